load_store_unit: RTL

//  Sits between the CPU core's MEM stage and the word-wide data memory (DMEM).

---
 rtl/lsu_pkg.sv | 28 ++
 rtl/lsu_align.sv | 45 ++++
 rtl/load_store_unit.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and fault-detection helper for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // 1 when the op must complete immediately with a fault (bad funct3 or misaligned).
  function automatic logic op_fault(input logic write, input logic [2:0] f3,
                                    input logic [1:0] addr_lo);
    logic fault;
    fault = 1'b0;
    case (f3)
      F3_B:         fault = 1'b0;
      F3_H:         fault = addr_lo[0];
      F3_W:         fault = (addr_lo != 2'b00);
      F3_BU:        fault = write;
      F3_HU:        fault = write | addr_lo[0];
      default:      fault = 1'b1;
    endcase
    return fault;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane datapath: extracts/extends load data and merges sub-word store data.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [4:0]  bsh;
  logic [4:0]  hsh;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign bsh    = {addr_lo_i, 3'b000};
  assign hsh    = {addr_lo_i[1], 4'b0000};
  assign lane_b = 8'(rdata_i >> bsh);
  assign lane_h = 16'(rdata_i >> hsh);

  // Load extraction with sign or zero extension.
  always_comb begin
    load_o = rdata_i;
    case (funct3_i)
      F3_B:    load_o = {{24{lane_b[7]}}, lane_b};
      F3_BU:   load_o = {24'h0, lane_b};
      F3_H:    load_o = {{16{lane_h[15]}}, lane_h};
      F3_HU:   load_o = {16'h0, lane_h};
      default: load_o = rdata_i;
    endcase
  end

  // Store merge: replace the addressed lane of the read word with store data.
  always_comb begin
    merge_o = wdata_i;
    case (funct3_i)
      F3_B:    merge_o = (rdata_i & ~(32'h0000_00FF << bsh)) | ({24'h0, wdata_i[7:0]} << bsh);
      F3_H:    merge_o = (rdata_i & ~(32'h0000_FFFF << hsh)) | ({16'h0, wdata_i[15:0]} << hsh);
      default: merge_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: req/ack DMEM master with read-modify-write for SB/SH.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              lsu_valid,
  input  logic              lsu_write,
  input  logic [2:0]        lsu_funct3,
  input  logic [31:0]       lsu_addr,
  input  logic [31:0]       lsu_wdata,
  output logic [31:0]       lsu_rdata,
  output logic              lsu_done,
  output logic              lsu_fault,
  output logic              lsu_busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  lsu_state_t        state_q, state_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              write_q, write_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              fault_q, fault_d;
  logic              busy_q, busy_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [31:0]       mwdata_q, mwdata_d;

  logic [31:0]       load_data;
  logic [31:0]       merge_data;

  lsu_align u_align (
    .funct3_i  (funct3_q),
    .addr_lo_i (addr_lo_q),
    .wdata_i   (wdata_q),
    .rdata_i   (mem_rdata),
    .load_o    (load_data),
    .merge_o   (merge_data)
  );

  // Next-state and next-output logic; every output is computed here and registered below.
  always_comb begin
    state_d   = state_q;
    addr_lo_d = addr_lo_q;
    funct3_d  = funct3_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    rdata_d   = 32'h0;
    done_d    = 1'b0;
    fault_d   = 1'b0;
    req_d     = req_q;
    we_d      = we_q;
    maddr_d   = maddr_q;
    mwdata_d  = mwdata_q;
    case (state_q)
      IDLE: begin
        if (lsu_valid) begin
          addr_lo_d = lsu_addr[1:0];
          funct3_d  = lsu_funct3;
          wdata_d   = lsu_wdata;
          write_d   = lsu_write;
          if (op_fault(lsu_write, lsu_funct3, lsu_addr[1:0])) begin
            state_d = DONE;
            done_d  = 1'b1;
            fault_d = 1'b1;
          end else begin
            req_d    = 1'b1;
            maddr_d  = lsu_addr[ADDR_W+1:2];
            mwdata_d = lsu_wdata;
            if (lsu_write && (lsu_funct3 == F3_W)) begin
              state_d = WR;
              we_d    = 1'b1;
            end else begin
              state_d = RD;
              we_d    = 1'b0;
            end
          end
        end
      end
      RD: begin
        if (mem_ack) begin
          if (write_q) begin
            // Sub-word store: keep the request up and turn it into the write half.
            state_d  = WR;
            we_d     = 1'b1;
            mwdata_d = merge_data;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            rdata_d = load_data;
            req_d   = 1'b0;
          end
        end
      end
      WR: begin
        if (mem_ack) begin
          state_d = DONE;
          done_d  = 1'b1;
          req_d   = 1'b0;
          we_d    = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset abandons any in-flight DMEM transaction.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= IDLE;
      addr_lo_q <= 2'b00;
      funct3_q  <= 3'b000;
      wdata_q   <= 32'h0;
      write_q   <= 1'b0;
      rdata_q   <= 32'h0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
      busy_q    <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      maddr_q   <= '0;
      mwdata_q  <= 32'h0;
    end else begin
      state_q   <= state_d;
      addr_lo_q <= addr_lo_d;
      funct3_q  <= funct3_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      rdata_q   <= rdata_d;
      done_q    <= done_d;
      fault_q   <= fault_d;
      busy_q    <= busy_d;
      req_q     <= req_d;
      we_q      <= we_d;
      maddr_q   <= maddr_d;
      mwdata_q  <= mwdata_d;
    end
  end

  assign lsu_rdata = rdata_q;
  assign lsu_done  = done_q;
  assign lsu_fault = fault_q;
  assign lsu_busy  = busy_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = maddr_q;
  assign mem_wdata = mwdata_q;

endmodule
